// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD sum display scanner: digit count and
// active-high 7-segment glyphs, with bit order {a,b,c,d,e,f,g}.
package bcd_disp_pkg;
    localparam int NUM_DIGITS = 5;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // True when a 4-bit code is not a legal BCD digit.
    function automatic logic is_non_bcd(input logic [3:0] d);
        return d > 4'd9;
    endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder. The output is active-high.
// Codes 10..15 display 'E'.
module bcd_to_seg7
    import bcd_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    // Glyph lookup
    always_comb begin
        seg = SEG_E;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end
endmodule

// File: rtl/bcd_sum_display_scanner.sv
// Captures a 17-bit BCD sum and scans it onto a 5-digit multiplexed
// 7-segment display.
// The anodes go inactive for one dead-time cycle at the start of each slot.
// The Blank input and non-BCD flagging are handled here too.
// Optional build macro LEADING_ZERO_BLANK_EN enables leading-zero suppression
// on digits 4..1.
module bcd_sum_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Load,
    input  logic [16:0]           Sum,
    input  logic                  Blank,
    output logic [6:0]            Seg,
    output logic [NUM_DIGITS-1:0] An,
    output logic                  Err
);
    localparam int            PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    logic [16:0]           shadow;
    logic [PW-1:0]         pre;
    logic [2:0]            idx;
    logic [3:0]            nib;
    logic [6:0]            seg_hi;
    logic [NUM_DIGITS-1:0] an_hi;
    logic [NUM_DIGITS-1:0] show;

    // Prescaler and digit index. The index steps once per slot.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            pre <= '0;
            idx <= '0;
        end else if (pre == PRE_LAST) begin
            pre <= '0;
            idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    // Shadow capture. Err tracks the non-BCD status of the captured value.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            shadow <= '0;
            Err    <= 1'b0;
        end else if (Load) begin
            shadow <= Sum;
            Err    <= is_non_bcd(Sum[3:0])  | is_non_bcd(Sum[7:4]) |
                      is_non_bcd(Sum[11:8]) | is_non_bcd(Sum[15:12]);
        end
    end

    // Select the nibble for the current slot. The carry digit is only 0 or 1.
    always_comb begin
        nib = 4'd0;
        case (idx)
            3'd0: nib = shadow[3:0];
            3'd1: nib = shadow[7:4];
            3'd2: nib = shadow[11:8];
            3'd3: nib = shadow[15:12];
            3'd4: nib = {3'b000, shadow[16]};
            default: nib = 4'd0;
        endcase
    end

    bcd_to_seg7 u_dec (
        .digit (nib),
        .seg   (seg_hi)
    );

    // Per-digit visibility. A digit above 9 is non-zero, so it stops suppression.
    always_comb begin
        show = '1;
`ifdef LEADING_ZERO_BLANK_EN
        show[4] = shadow[16];
        show[3] = show[4] | (shadow[15:12] != 4'd0);
        show[2] = show[3] | (shadow[11:8]  != 4'd0);
        show[1] = show[2] | (shadow[7:4]   != 4'd0);
        show[0] = 1'b1;
`endif
    end

    // Anode enable. Anodes are off for Blank, the dead-time cycle and suppressed digits.
    always_comb begin
        an_hi = '0;
        if (!Blank && (pre != '0) && show[idx])
            an_hi = NUM_DIGITS'(1) << idx;
    end

    // Output registers. Output polarity is applied here.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            Seg <= {7{SEG_ACTIVE_LOW}};
            An  <= {NUM_DIGITS{SEG_ACTIVE_LOW}};
        end else begin
            Seg <= seg_hi ^ {7{SEG_ACTIVE_LOW}};
            An  <= an_hi  ^ {NUM_DIGITS{SEG_ACTIVE_LOW}};
        end
    end
endmodule

// File: tb/tb_bcd_sum_display_scanner.sv
// Bench for bcd_sum_display_scanner with SCAN_DIV=4.
// Two instances run side by side, one active-high and one active-low.
// Each clock, both are compared against a reference model. The model derives
// the slot number and the phase inside the slot from the count of edges
// since reset.
module tb_bcd_sum_display_scanner;
    localparam int SD = 4;

    logic        Clk = 1'b0;
    logic        Rst, Load, Blank;
    logic [16:0] Sum;
    logic [6:0]  seg_h, seg_l;
    logic [4:0]  an_h, an_l;
    logic        err_h, err_l;

    int          total = 0;
    int          bad   = 0;
    int          e;
    logic [16:0] m_shadow;
    logic [6:0]  glyph [16];

    bcd_sum_display_scanner #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) u_dut_h (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Sum(Sum), .Blank(Blank),
        .Seg(seg_h), .An(an_h), .Err(err_h));

    bcd_sum_display_scanner #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) u_dut_l (
        .Clk(Clk), .Rst(Rst), .Load(Load), .Sum(Sum), .Blank(Blank),
        .Seg(seg_l), .An(an_l), .Err(err_l));

    always #5 Clk = ~Clk;

    function automatic logic [3:0] digit_of(input logic [16:0] s, input int k);
        if (k == 4) return {3'b000, s[16]};
        return s[4*k +: 4];
    endfunction

    function automatic logic shown(input logic [16:0] s, input int k);
`ifdef LEADING_ZERO_BLANK_EN
        if (k == 0) return 1'b1;
        for (int j = k; j <= 4; j++)
            if (digit_of(s, j) != 4'd0) return 1'b1;
        return 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic rst_chk(input string tag);
        total++; assert (seg_h === 7'h00) else begin bad++; $error("FAIL %s seg_h got=%b exp=%b", tag, seg_h, 7'h00); end
        total++; assert (an_h === 5'h00) else begin bad++; $error("FAIL %s an_h got=%b exp=%b", tag, an_h, 5'h00); end
        total++; assert (err_h === 1'b0) else begin bad++; $error("FAIL %s err_h got=%b exp=0", tag, err_h); end
        total++; assert (seg_l === 7'h7f) else begin bad++; $error("FAIL %s seg_l got=%b exp=%b", tag, seg_l, 7'h7f); end
        total++; assert (an_l === 5'h1f) else begin bad++; $error("FAIL %s an_l got=%b exp=%b", tag, an_l, 5'h1f); end
        total++; assert (err_l === 1'b0) else begin bad++; $error("FAIL %s err_l got=%b exp=0", tag, err_l); end
    endtask

    // One clock of stimulus. The expected outputs come from the model state
    // as it stands before the edge.
    task automatic tick(input logic l, input logic [16:0] s, input logic b);
        int         slot, phase;
        logic [6:0] xs;
        logic [4:0] xa;
        logic       xe;
        Load = l; Sum = s; Blank = b;
        slot  = (e / SD) % 5;
        phase = e % SD;
        xs = glyph[digit_of(m_shadow, slot)];
        xa = (b || phase == 0 || !shown(m_shadow, slot)) ? 5'd0 : 5'(1 << slot);
        if (l) m_shadow = s;
        xe = 1'b0;
        for (int k = 0; k < 4; k++) if (digit_of(m_shadow, k) > 4'd9) xe = 1'b1;
        @(posedge Clk);
        e++;
        #1;
        total++; assert (seg_h === xs) else begin bad++; $error("FAIL seg_h e=%0d got=%b exp=%b", e, seg_h, xs); end
        total++; assert (an_h === xa) else begin bad++; $error("FAIL an_h e=%0d got=%b exp=%b", e, an_h, xa); end
        total++; assert (err_h === xe) else begin bad++; $error("FAIL err_h e=%0d got=%b exp=%b", e, err_h, xe); end
        total++; assert (seg_l === ~xs) else begin bad++; $error("FAIL seg_l e=%0d got=%b exp=%b", e, seg_l, ~xs); end
        total++; assert (an_l === ~xa) else begin bad++; $error("FAIL an_l e=%0d got=%b exp=%b", e, an_l, ~xa); end
        total++; assert (err_l === xe) else begin bad++; $error("FAIL err_l e=%0d got=%b exp=%b", e, err_l, xe); end
    endtask

    function automatic logic [16:0] rand_sum();
        logic [16:0] s;
        s[16] = 1'($urandom % 2);
        for (int k = 0; k < 4; k++) begin
            if ($urandom % 4 == 0)      s[4*k +: 4] = 4'($urandom % 16);
            else if ($urandom % 3 == 0) s[4*k +: 4] = 4'd0;
            else                        s[4*k +: 4] = 4'($urandom % 10);
        end
        return s;
    endfunction

    initial begin
        glyph[0] = 7'b1111110; glyph[1] = 7'b0110000; glyph[2] = 7'b1101101;
        glyph[3] = 7'b1111001; glyph[4] = 7'b0110011; glyph[5] = 7'b1011011;
        glyph[6] = 7'b1011111; glyph[7] = 7'b1110000; glyph[8] = 7'b1111111;
        glyph[9] = 7'b1111011;
        for (int i = 10; i < 16; i++) glyph[i] = 7'b1001111;

        // Reset held, then released away from the clock edge
        Rst = 1'b1; Load = 1'b0; Blank = 1'b0; Sum = '0;
        e = 0; m_shadow = '0;
        repeat (2) @(posedge Clk);
        #1 rst_chk("reset");
        #3 Rst = 1'b0;
        repeat (6) tick(1'b0, 17'h0, 1'b0);

        // Scan of 12345
        tick(1'b1, 17'h12345, 1'b0);
        repeat (24) tick(1'b0, 17'h0, 1'b0);

        // Non-BCD digit, then a clean value
        tick(1'b1, 17'h0A009, 1'b0);
        repeat (20) tick(1'b0, 17'h0, 1'b0);
        tick(1'b1, 17'h00009, 1'b0);
        repeat (6) tick(1'b0, 17'h0, 1'b0);

        // Blank for 10 clocks, then resume
        repeat (10) tick(1'b0, 17'h0, 1'b1);
        repeat (12) tick(1'b0, 17'h0, 1'b0);

        // Leading zeros
        tick(1'b1, 17'h00070, 1'b0);
        repeat (24) tick(1'b0, 17'h0, 1'b0);

        // Load while blanked
        tick(1'b1, 17'h19999, 1'b1);
        repeat (10) tick(1'b0, 17'h0, 1'b0);

        // Load landing on every phase, including the terminal count
        for (int p = 0; p < SD; p++) begin
            tick(1'b1, rand_sum(), 1'b0);
            repeat (SD) tick(1'b0, 17'h0, 1'b0);
        end

        // Random traffic
        repeat (300) tick(($urandom % 5) == 0, rand_sum(), ($urandom % 8) == 0);

        // Reset asserted mid-slot
        #2 Rst = 1'b1;
        #1 rst_chk("midrst");
        @(posedge Clk);
        #1 rst_chk("midrst_hold");
        #3 Rst = 1'b0;
        e = 0; m_shadow = '0;
        repeat (8) tick(1'b0, 17'h0, 1'b0);
        tick(1'b1, 17'h1F0E2, 1'b0);
        repeat (24) tick(1'b0, 17'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
